// File: rtl/vec_seq_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_seq_unit: multi-cycle vector register file and element-wise ALU that |
// | processes LANES_PER_BEAT elements per beat. Optional macro VEC_REDUCE_EN |
// | enables reduce-sum (op 110). Revision: 1.0                               |
// +--------------------------------------------------------------------------+
module vec_seq_unit #(
    parameter int WIDTH          = 32,
    parameter int VLEN           = 5,
    parameter int NREG           = 16,
    parameter int LANES_PER_BEAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [$clog2(NREG)-1:0]  va1,
    input  logic [$clog2(NREG)-1:0]  va2,
    input  logic [$clog2(NREG)-1:0]  vd,
    input  logic                     use_imm,
    input  logic [WIDTH-1:0]         imm,
    output logic                     ready,
    output logic                     done,
    output logic [WIDTH-1:0]         scalar_result,
    input  logic                     idx_we,
    input  logic [$clog2(NREG)-1:0]  idx_vd,
    input  logic [$clog2(VLEN):0]    idx,
    input  logic [WIDTH-1:0]         idx_data,
    input  logic [$clog2(NREG)-1:0]  rd_addr,
    input  logic [$clog2(VLEN):0]    rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int c_AW    = $clog2(NREG);
    localparam int c_IW    = $clog2(VLEN) + 1;
    localparam int c_P     = LANES_PER_BEAT;
    localparam int c_BEATS = (VLEN + c_P - 1) / c_P;
    localparam int c_BW    = $clog2(c_BEATS + 1);
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_BEATS - 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_MOV = 3'b101;

    // S_FIN separates the last beat write from the done pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [c_BW-1:0]   r_beat;
    logic [2:0]        r_op;
    logic [c_AW-1:0]   r_va1;
    logic [c_AW-1:0]   r_va2;
    logic [c_AW-1:0]   r_vd;
    logic              r_use_imm;
    logic [WIDTH-1:0]  r_imm;
    logic              r_ready;
    logic              r_done;
    logic [WIDTH-1:0]  r_vreg [NREG][VLEN];

    logic [WIDTH-1:0]  w_a   [c_P];
    logic [WIDTH-1:0]  w_b   [c_P];
    logic [WIDTH-1:0]  w_res [c_P];
    logic              w_wr_en;

    assign ready   = r_ready;
    assign done    = r_done;
    assign w_wr_en = (r_op <= c_OP_MOV);

    // Lane l of beat k handles element k*P+l; lanes past VLEN stay at zero.
    always_comb begin
        for (int l = 0; l < c_P; l++) begin
            w_a[l] = '0;
            w_b[l] = '0;
            for (int e = 0; e < VLEN; e++) begin
                if ((e % c_P) == l && r_beat == c_BW'(e / c_P)) begin
                    w_a[l] = r_vreg[r_va1][e];
                    w_b[l] = r_use_imm ? r_imm : r_vreg[r_va2][e];
                end
            end
            case (r_op)
                c_OP_ADD: w_res[l] = w_a[l] + w_b[l];
                c_OP_SUB: w_res[l] = w_a[l] - w_b[l];
                c_OP_AND: w_res[l] = w_a[l] & w_b[l];
                c_OP_OR:  w_res[l] = w_a[l] | w_b[l];
                c_OP_XOR: w_res[l] = w_a[l] ^ w_b[l];
                c_OP_MOV: w_res[l] = w_b[l];
                default:  w_res[l] = '0;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        for (int e = 0; e < VLEN; e++) begin
            if (rd_idx == c_IW'(e)) rd_data = r_vreg[rd_addr][e];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_op      <= '0;
            r_va1     <= '0;
            r_va2     <= '0;
            r_vd      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            for (int n = 0; n < NREG; n++) begin
                for (int e = 0; e < VLEN; e++) r_vreg[n][e] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (idx_we) begin
                        for (int e = 0; e < VLEN; e++) begin
                            if (idx == c_IW'(e)) r_vreg[idx_vd][e] <= idx_data;
                        end
                    end
                    if (start) begin
                        r_op      <= op;
                        r_va1     <= va1;
                        r_va2     <= va2;
                        r_vd      <= vd;
                        r_use_imm <= use_imm;
                        r_imm     <= imm;
                        r_beat    <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    for (int e = 0; e < VLEN; e++) begin
                        if (w_wr_en && r_beat == c_BW'(e / c_P))
                            r_vreg[r_vd][e] <= w_res[e % c_P];
                    end
                    if (r_beat == c_LAST_BEAT) begin
                        r_beat  <= '0;
                        r_state <= S_FIN;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VEC_REDUCE_EN
    localparam logic [2:0] c_OP_RED = 3'b110;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_scalar;
    logic [WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < c_P; l++) w_sum = w_sum + w_a[l];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_scalar <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_acc <= '0;
            else if (r_state == S_EXEC && r_op == c_OP_RED) r_acc <= r_acc + w_sum;
            if (r_state == S_FIN && r_op == c_OP_RED) r_scalar <= r_acc;
        end
    end

    assign scalar_result = r_scalar;
`else
    assign scalar_result = '0;
`endif

endmodule
`default_nettype wire
